rv32i_wb_sched: RTL

Write-back scheduler and scoreboard for the 16-entry register bank. It shares the bank's single write port between two requesters, the ALU and the load/store unit, using round-robin arbitration. It also tracks one busy bit per register, so issue stalls on RAW/WAW hazards until the pending write has reached the bank. It sits between execute/LSU and the register bank, and drives the bank's we/rd/din inputs.

---
 rtl/rv32i_pkg.sv | 13 +
 rtl/rv32i_rr_arb2.sv | 29 ++
 rtl/rv32i_wb_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared widths and requester identifiers for the register-bank write-back path.
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 16;
    localparam int REG_AW = 4;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage

// File: rtl/rv32i_rr_arb2.sv
// Two-way round-robin arbiter; the pointer records the last requester that transferred.
module rv32i_rr_arb2
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    req_e last;

    always_comb begin
        gnt          = '0;
        gnt[REQ_ALU] = req[REQ_ALU] && (!req[REQ_LSU] || (last == REQ_LSU));
        gnt[REQ_LSU] = req[REQ_LSU] && (!req[REQ_ALU] || (last == REQ_ALU));
    end

    // Pointer moves only on an actual transfer; reset favours the ALU on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= REQ_LSU;
        end else if (adv) begin
            last <= gnt[REQ_LSU] ? REQ_LSU : REQ_ALU;
        end
    end

endmodule

// File: rtl/rv32i_wb_sched.sv
// Write-back scheduler: arbitrates the bank write port between ALU and LSU and keeps
// a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module rv32i_wb_sched
    import rv32i_pkg::*;
#(
    parameter int XLEN = rv32i_pkg::XLEN,
    parameter int NREG = rv32i_pkg::NREG
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              is_upper_i,
    input  logic              iss_valid_i,
    input  logic [REG_AW-1:0] iss_rs1_i,
    input  logic [REG_AW-1:0] iss_rs2_i,
    input  logic [REG_AW-1:0] iss_rd_i,
    input  logic              iss_wr_i,
    output logic              iss_stall_o,
    input  logic              alu_valid_i,
    input  logic [REG_AW-1:0] alu_rd_i,
    input  logic [XLEN-1:0]   alu_data_i,
    output logic              alu_ready_o,
    input  logic              lsu_valid_i,
    input  logic [REG_AW-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]   lsu_data_i,
    output logic              lsu_ready_o,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_rd_o,
    output logic [XLEN-1:0]   rf_din_o,
    output logic [NREG-1:0]   busy_o,
    output logic              err_o
);

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;
    logic              err;
    logic              rf_we;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_din;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              xfer;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    function automatic logic is_zero(input logic upper, input logic [REG_AW-1:0] r);
        return !upper && (r == '0);
    endfunction

    function automatic logic busy_at(input logic [NREG-1:0] b, input logic upper,
                                     input logic [REG_AW-1:0] r);
        return b[r] && !is_zero(upper, r);
    endfunction

    assign iss_stall_o = iss_valid_i &&
                         (busy_at(busy, is_upper_i, iss_rs1_i) ||
                          busy_at(busy, is_upper_i, iss_rs2_i) ||
                          (iss_wr_i && busy_at(busy, is_upper_i, iss_rd_i)));

    assign req = {lsu_valid_i, alu_valid_i};

    rv32i_rr_arb2 u_arb (
        .clk (clk_i),
        .rst (rst_i),
        .req (req),
        .adv (xfer),
        .gnt (gnt)
    );

    assign alu_ready_o = gnt[REQ_ALU];
    assign lsu_ready_o = gnt[REQ_LSU];
    assign xfer        = |(req & gnt);
    assign wb_rd       = gnt[REQ_LSU] ? lsu_rd_i   : alu_rd_i;
    assign wb_data     = gnt[REQ_LSU] ? lsu_data_i : alu_data_i;

    // Set from an accepted issue, clear from the write currently presented to the bank.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid_i && !iss_stall_o && iss_wr_i && !is_zero(is_upper_i, iss_rd_i)) begin
            set_mask[iss_rd_i] = 1'b1;
        end
        if (rf_we) begin
            clr_mask[rf_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy   <= '0;
            err    <= 1'b0;
            rf_we  <= 1'b0;
            rf_rd  <= '0;
            rf_din <= '0;
        end else begin
            busy  <= (busy & ~clr_mask) | set_mask;
            if (rf_we && !busy[rf_rd]) begin
                err <= 1'b1;
            end
            rf_we <= xfer && !is_zero(is_upper_i, wb_rd);
            if (xfer) begin
                rf_rd  <= wb_rd;
                rf_din <= wb_data;
            end
        end
    end

    assign busy_o   = busy;
    assign err_o    = err;
    assign rf_we_o  = rf_we;
    assign rf_rd_o  = rf_rd;
    assign rf_din_o = rf_din;

endmodule
